hazard_stall_unit: RTL and testbench



---
 rtl/hazard_stall_unit.sv | 148 ++++++++++++++
 tb/tb_hazard_stall_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: ID-stage stall/flush decision, SRAM-wait pipeline freeze,
// stall-cycle performance counter and sticky SRAM-timeout flag.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_RUN    | no SRAM access outstanding; wait_cnt held at 0
// ST_WAIT   | MEM stage waiting on mem_ready; wait_cnt counts wait cycles
module hazard_stall_unit #(
    parameter int REG_ADDR_LEN = 4,
    parameter int WAIT_TIMEOUT = 63,
    parameter int CNT_W        = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_forwarding,
    input  logic                    id_valid,
    input  logic [REG_ADDR_LEN-1:0] id_src1,
    input  logic [REG_ADDR_LEN-1:0] id_src2,
    input  logic                    id_two_src,
    input  logic [REG_ADDR_LEN-1:0] exe_dst,
    input  logic                    exe_wb_en,
    input  logic                    exe_mem_r_en,
    input  logic [REG_ADDR_LEN-1:0] mem_dst,
    input  logic                    mem_wb_en,
    input  logic                    mem_req,
    input  logic                    mem_ready,
    input  logic                    branch_taken,
    output logic                    hazard_stall,
    output logic                    id_ex_flush,
    output logic                    pipe_freeze,
    output logic                    mem_timeout,
    output logic [CNT_W-1:0]        stall_count
);

    localparam int WCW = (WAIT_TIMEOUT < 1) ? 1 : $clog2(WAIT_TIMEOUT + 1);
    localparam logic [WCW-1:0] TIMEOUT_CNT = WCW'(WAIT_TIMEOUT);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
    logic             mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic raw_exe;
    logic raw_mem;
    logic hz;
    logic at_timeout;

    // Source/destination matches; r0 is an ordinary register here.
    always_comb begin
        raw_exe = exe_wb_en && ((exe_dst == id_src1) ||
                                (id_two_src && (exe_dst == id_src2)));
        raw_mem = mem_wb_en && ((mem_dst == id_src1) ||
                                (id_two_src && (mem_dst == id_src2)));
        if (en_forwarding)
            hz = id_valid && raw_exe && exe_mem_r_en;
        else
            hz = id_valid && (raw_exe || raw_mem);
    end

    // Mealy control outputs: freeze beats branch squash beats hazard stall.
    always_comb begin
        at_timeout  = (wait_cnt_q == TIMEOUT_CNT);
        pipe_freeze = 1'b0;
        if (state_q == ST_RUN)
            pipe_freeze = mem_req && !mem_ready;
        else
            pipe_freeze = !mem_ready && !at_timeout;

        hazard_stall = 1'b0;
        id_ex_flush  = 1'b0;
        if (!pipe_freeze) begin
            if (branch_taken) begin
                id_ex_flush = 1'b1;
            end else begin
                hazard_stall = hz;
                id_ex_flush  = hz;
            end
        end
    end

    // Next-state for the SRAM wait FSM, its wait counter and the timeout flag.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        case (state_q)
            ST_RUN: begin
                wait_cnt_d = '0;
                if (mem_req && !mem_ready)
                    state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_ready) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (at_timeout) begin
                    // Forced release: the access is abandoned and flagged.
                    state_d       = ST_RUN;
                    wait_cnt_d    = '0;
                    mem_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Saturating count of cycles spent stalled or frozen.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((hazard_stall || pipe_freeze) && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    // FSM register bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    // Performance counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt_q <= '0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign mem_timeout = mem_timeout_q;
    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Testbench for hazard_stall_unit: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the control rules.
module tb_hazard_stall_unit;

    localparam int RA   = 4;
    localparam int WTO  = 3;
    localparam int CW   = 12;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en_forwarding, id_valid, id_two_src;
    logic [RA-1:0] id_src1, id_src2, exe_dst, mem_dst;
    logic          exe_wb_en, exe_mem_r_en, mem_wb_en;
    logic          mem_req, mem_ready, branch_taken;
    logic          hazard_stall, id_ex_flush, pipe_freeze, mem_timeout;
    logic [CW-1:0] stall_count;

    int n_checks = 0;
    int n_pass   = 0;

    // model state: age of the outstanding SRAM access (-1 = none)
    int m_wait_age = -1;
    int m_count    = 0;
    bit m_timeout  = 1'b0;
    int freeze_seen;

    hazard_stall_unit #(.REG_ADDR_LEN(RA), .WAIT_TIMEOUT(WTO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .en_forwarding(en_forwarding), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .exe_dst(exe_dst), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dst(mem_dst), .mem_wb_en(mem_wb_en), .mem_req(mem_req),
        .mem_ready(mem_ready), .branch_taken(branch_taken),
        .hazard_stall(hazard_stall), .id_ex_flush(id_ex_flush),
        .pipe_freeze(pipe_freeze), .mem_timeout(mem_timeout),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic set_idle();
        en_forwarding = 1'b1; id_valid = 1'b0; id_two_src = 1'b0;
        id_src1 = '0; id_src2 = '0; exe_dst = '0; mem_dst = '0;
        exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; mem_wb_en = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
    endtask

    function automatic bit reads(input logic [RA-1:0] dst);
        return (dst == id_src1) || (id_two_src && dst == id_src2);
    endfunction

    // Settle, compare all outputs to the model, then advance the model
    // to what the coming rising edge should produce.
    task automatic check_cycle();
        bit hz, frz, e_stall, e_flush;
        #2;
        if (en_forwarding)
            hz = id_valid && exe_wb_en && exe_mem_r_en && reads(exe_dst);
        else
            hz = id_valid && ((exe_wb_en && reads(exe_dst)) || (mem_wb_en && reads(mem_dst)));
        if (m_wait_age < 0) frz = mem_req && !mem_ready;
        else                frz = !mem_ready && (m_wait_age != WTO);
        e_stall = !frz && !branch_taken && hz;
        e_flush = !frz && (branch_taken || hz);

        check_eq("pipe_freeze",  32'(pipe_freeze),  32'(frz));
        check_eq("hazard_stall", 32'(hazard_stall), 32'(e_stall));
        check_eq("id_ex_flush",  32'(id_ex_flush),  32'(e_flush));
        check_eq("mem_timeout",  32'(mem_timeout),  32'(m_timeout));
        check_eq("stall_count",  32'(stall_count),  32'(m_count));

        if ((e_stall || frz) && m_count < CMAX) m_count++;
        if (m_wait_age < 0) begin
            if (mem_req && !mem_ready) m_wait_age = 0;
        end else if (mem_ready) begin
            m_wait_age = -1;
        end else if (m_wait_age == WTO) begin
            m_wait_age = -1;
            m_timeout  = 1'b1;
        end else begin
            m_wait_age++;
        end
    endtask

    task automatic model_reset();
        m_wait_age = -1;
        m_count    = 0;
        m_timeout  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_idle();
        rst = 1'b1;
        model_reset();
        #2;
        check_eq("rst_stall_count", 32'(stall_count), 32'd0);
        check_eq("rst_mem_timeout", 32'(mem_timeout), 32'd0);
        check_eq("rst_pipe_freeze", 32'(pipe_freeze), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        set_idle();
        do_reset();

        // load-use with forwarding on: exactly one stall cycle
        @(negedge clk); set_idle();
        id_valid = 1; id_src1 = 3; exe_dst = 3; exe_wb_en = 1; exe_mem_r_en = 1;
        check_cycle();
        check_eq("lu_stall", 32'(hazard_stall), 32'd1);
        check_eq("lu_flush", 32'(id_ex_flush), 32'd1);
        @(negedge clk); set_idle();
        id_valid = 1; id_src1 = 3; mem_dst = 3; mem_wb_en = 1;
        check_cycle();
        check_eq("lu_after", 32'(hazard_stall), 32'd0);
        check_eq("lu_count", 32'(stall_count), 32'd1);

        // ALU writer with forwarding on: no stall
        @(negedge clk); set_idle();
        id_valid = 1; id_src1 = 3; exe_dst = 3; exe_wb_en = 1;
        check_cycle();
        check_eq("alu_fwd_nostall", 32'(hazard_stall), 32'd0);

        // forwarding off: writer in EXE then MEM -> two stall cycles
        @(negedge clk); set_idle(); en_forwarding = 0;
        id_valid = 1; id_src1 = 3; exe_dst = 3; exe_wb_en = 1;
        check_cycle();
        check_eq("nofwd_exe", 32'(hazard_stall), 32'd1);
        @(negedge clk); set_idle(); en_forwarding = 0;
        id_valid = 1; id_src1 = 3; mem_dst = 3; mem_wb_en = 1;
        check_cycle();
        check_eq("nofwd_mem", 32'(hazard_stall), 32'd1);
        @(negedge clk); set_idle(); en_forwarding = 0;
        id_valid = 1; id_src1 = 3;
        check_cycle();
        check_eq("nofwd_done", 32'(hazard_stall), 32'd0);

        // src2 only counts when id_two_src is set
        @(negedge clk); set_idle();
        id_valid = 1; id_src1 = 1; id_src2 = 5; exe_dst = 5; exe_wb_en = 1; exe_mem_r_en = 1;
        check_cycle();
        check_eq("src2_unused", 32'(hazard_stall), 32'd0);
        @(negedge clk); id_two_src = 1;
        check_cycle();
        check_eq("src2_used", 32'(hazard_stall), 32'd1);

        // branch squashes a load-use hazard
        @(negedge clk); branch_taken = 1;
        check_cycle();
        check_eq("br_stall", 32'(hazard_stall), 32'd0);
        check_eq("br_flush", 32'(id_ex_flush), 32'd1);

        // SRAM ready 4 cycles after request, with a concurrent hazard
        freeze_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); set_idle();
            id_valid = 1; id_src1 = 3; exe_dst = 3; exe_wb_en = 1; exe_mem_r_en = 1;
            mem_req = 1; mem_ready = (i == 4);
            check_cycle();
            if (pipe_freeze) freeze_seen++;
            if (i < 4) check_eq("frz_no_stall", 32'(hazard_stall), 32'd0);
        end
        check_eq("frz_len", 32'(freeze_seen), 32'd4);
        @(negedge clk); set_idle();
        check_cycle();
        check_eq("frz_back_run", 32'(pipe_freeze), 32'd0);

        // SRAM never ready: forced release and sticky timeout
        check_eq("to_before", 32'(mem_timeout), 32'd0);
        freeze_seen = 0;
        for (int i = 0; i < WTO + 2; i++) begin
            @(negedge clk); set_idle(); mem_req = 1;
            check_cycle();
            if (pipe_freeze) freeze_seen++;
        end
        check_eq("to_frz_len", 32'(freeze_seen), 32'(WTO + 1));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); set_idle();
            check_cycle();
            check_eq("to_sticky", 32'(mem_timeout), 32'd1);
        end

        // reset in the middle of a wait
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); set_idle(); mem_req = 1;
            check_cycle();
        end
        #1; set_idle(); rst = 1; model_reset();
        #1;
        check_eq("rstw_freeze", 32'(pipe_freeze), 32'd0);
        check_eq("rstw_stall",  32'(hazard_stall), 32'd0);
        check_eq("rstw_flush",  32'(id_ex_flush), 32'd0);
        check_eq("rstw_to",     32'(mem_timeout), 32'd0);
        check_eq("rstw_cnt",    32'(stall_count), 32'd0);
        @(negedge clk); rst = 0;

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            en_forwarding = 1'($urandom_range(0, 1));
            id_valid      = ($urandom_range(0, 9) < 8);
            id_src1       = RA'($urandom_range(0, 3));
            id_src2       = RA'($urandom_range(0, 3));
            id_two_src    = 1'($urandom_range(0, 1));
            exe_dst       = RA'($urandom_range(0, 3));
            exe_wb_en     = 1'($urandom_range(0, 1));
            exe_mem_r_en  = 1'($urandom_range(0, 1));
            mem_dst       = RA'($urandom_range(0, 3));
            mem_wb_en     = 1'($urandom_range(0, 1));
            mem_req       = ($urandom_range(0, 9) < 3);
            mem_ready     = ($urandom_range(0, 9) < 3);
            branch_taken  = ($urandom_range(0, 9) < 1);
            check_cycle();
        end

        // drive the counter into saturation
        do_reset();
        for (int i = 0; i < CMAX + 5; i++) begin
            @(negedge clk); set_idle();
            id_valid = 1; id_src1 = 7; exe_dst = 7; exe_wb_en = 1; exe_mem_r_en = 1;
            check_cycle();
        end
        @(negedge clk); set_idle();
        #2;
        check_eq("cnt_saturated", 32'(stall_count), 32'(CMAX));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
